// File: rtl/clut_pkg.sv
// Shared types and constants for the CLUT sequencer.
// Optional build macro: CLUT_FORWARD_EN (pending-write forwarding to pixel reads).
package clut_pkg;

  localparam int LEN    = 256;
  localparam int ADDR_W = 8;

  localparam int R_LSB = 0;
  localparam int G_LSB = 8;
  localparam int B_LSB = 16;

  typedef enum logic [1:0] {
    S_R,
    S_G,
    S_B
  } host_state_t;

  function automatic logic [23:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    logic [23:0] w;
    w = '0;
    w[R_LSB +: 8] = r;
    w[G_LSB +: 8] = g;
    w[B_LSB +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/clut_host_assembler.sv
// Host palette write path: R/G/B byte sequencer, auto-incrementing index and
// a one-deep pending entry that the arbiter drains via i_commit.
module clut_host_assembler
  import clut_pkg::*;
#(
  parameter int LEN   = clut_pkg::LEN,
  parameter int IDX_W = clut_pkg::ADDR_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_idx_wr,
  input  logic             i_data_wr,
  input  logic [7:0]       i_data,
  input  logic             i_commit,
  output logic             o_host_ready,
  output logic             pend_valid,
  output logic [IDX_W-1:0] pend_idx,
  output logic [23:0]      pend_data
);

  host_state_t      state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [7:0]       r_reg;
  logic [7:0]       g_reg;
  logic             accept;

  // Only the B byte needs a free pending slot, so R and G keep flowing.
  assign o_host_ready = !(state_reg == S_B && pend_valid);
  assign accept       = i_data_wr && o_host_ready && !i_idx_wr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg  <= S_R;
      idx_reg    <= '0;
      r_reg      <= '0;
      g_reg      <= '0;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      pend_data  <= '0;
    end else begin
      if (i_commit) begin
        pend_valid <= 1'b0;
      end
      if (i_idx_wr) begin
        idx_reg   <= i_data[IDX_W-1:0];
        r_reg     <= '0;
        g_reg     <= '0;
        state_reg <= S_R;
      end else if (accept) begin
        case (state_reg)
          S_R: begin
            r_reg     <= i_data;
            state_reg <= S_G;
          end
          S_G: begin
            g_reg     <= i_data;
            state_reg <= S_B;
          end
          S_B: begin
            pend_valid <= 1'b1;
            pend_idx   <= idx_reg;
            pend_data  <= pack_rgb(r_reg, g_reg, i_data);
            idx_reg    <= (idx_reg == IDX_W'(LEN - 1)) ? '0 : idx_reg + 1'b1;
            state_reg  <= S_R;
          end
          default: state_reg <= S_R;
        endcase
      end
    end
  end

endmodule

// File: rtl/clut_controller.sv
// Single-port CLUT arbiter: pixel lookups take priority, host writes drain
// on idle cycles. Optional build macro: CLUT_FORWARD_EN.
module clut_controller
  import clut_pkg::*;
#(
  parameter int LEN    = clut_pkg::LEN,
  parameter int ADDR_W = clut_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_host_idx_wr,
  input  logic              i_host_data_wr,
  input  logic [7:0]        i_host_data,
  output logic              o_host_ready,
  input  logic              i_pix_valid,
  input  logic [ADDR_W-1:0] i_pix_index,
  output logic              o_pix_valid,
  output logic [7:0]        o_r,
  output logic [7:0]        o_g,
  output logic [7:0]        o_b,
  output logic [ADDR_W-1:0] o_ram_entry,
  output logic              o_ram_we,
  output logic [23:0]       o_ram_data,
  input  logic [23:0]       i_ram_data
);

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_idx;
  logic [23:0]       pend_data;
  logic              commit;
  logic              pix_d1_reg;
  logic [23:0]       result_word;

  assign commit = !i_pix_valid && pend_valid;

  clut_host_assembler #(
    .LEN   (LEN),
    .IDX_W (ADDR_W)
  ) u_host (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_idx_wr     (i_host_idx_wr),
    .i_data_wr    (i_host_data_wr),
    .i_data       (i_host_data),
    .i_commit     (commit),
    .o_host_ready (o_host_ready),
    .pend_valid   (pend_valid),
    .pend_idx     (pend_idx),
    .pend_data    (pend_data)
  );

  assign o_ram_entry = i_pix_valid ? i_pix_index : pend_idx;
  assign o_ram_we    = commit;
  assign o_ram_data  = pend_data;

`ifdef CLUT_FORWARD_EN
  logic        hit_d1_reg;
  logic [23:0] fwd_d1_reg;

  // A lookup of the still-pending index sees the new entry, not the stale RAM word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hit_d1_reg <= 1'b0;
      fwd_d1_reg <= '0;
    end else begin
      hit_d1_reg <= i_pix_valid && pend_valid && (i_pix_index == pend_idx);
      fwd_d1_reg <= pend_data;
    end
  end

  assign result_word = hit_d1_reg ? fwd_d1_reg : i_ram_data;
`else
  assign result_word = i_ram_data;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pix_d1_reg  <= 1'b0;
      o_pix_valid <= 1'b0;
      o_r         <= '0;
      o_g         <= '0;
      o_b         <= '0;
    end else begin
      pix_d1_reg  <= i_pix_valid;
      o_pix_valid <= pix_d1_reg;
      if (pix_d1_reg) begin
        o_r <= result_word[R_LSB +: 8];
        o_g <= result_word[G_LSB +: 8];
        o_b <= result_word[B_LSB +: 8];
      end
    end
  end

endmodule

// File: tb/tb_clut_controller.sv
// Randomized bench for clut_controller with an external RAM model and a
// transaction-level palette reference model.
module tb_clut_controller;

`ifdef CLUT_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_host_idx_wr = 1'b0;
  logic        i_host_data_wr = 1'b0;
  logic [7:0]  i_host_data = '0;
  logic        o_host_ready;
  logic        i_pix_valid = 1'b0;
  logic [7:0]  i_pix_index = '0;
  logic        o_pix_valid;
  logic [7:0]  o_r, o_g, o_b;
  logic [7:0]  o_ram_entry;
  logic        o_ram_we;
  logic [23:0] o_ram_data;
  logic [23:0] i_ram_data;

  always #5 i_clk = ~i_clk;

  clut_controller dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_host_idx_wr  (i_host_idx_wr),
    .i_host_data_wr (i_host_data_wr),
    .i_host_data    (i_host_data),
    .o_host_ready   (o_host_ready),
    .i_pix_valid    (i_pix_valid),
    .i_pix_index    (i_pix_index),
    .o_pix_valid    (o_pix_valid),
    .o_r            (o_r),
    .o_g            (o_g),
    .o_b            (o_b),
    .o_ram_entry    (o_ram_entry),
    .o_ram_we       (o_ram_we),
    .o_ram_data     (o_ram_data),
    .i_ram_data     (i_ram_data)
  );

  function automatic logic [23:0] init_val(input int i);
    return 24'((i * 32'h0001_0307) ^ 32'h0000_A55A);
  endfunction

  // Read-first single-port RAM behind the controller.
  logic [23:0] ram [256];
  logic        ram_load = 1'b1;
  always @(posedge i_clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (o_ram_we) begin
      ram[o_ram_entry] <= o_ram_data;
    end else begin
      i_ram_data <= ram[o_ram_entry];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [23:0] exp_mem [256];
  logic [7:0]  m_idx, m_r, m_g, m_pidx;
  int          m_phase;
  logic        m_pv;
  logic [23:0] m_pdata;
  logic        m_p1_v, m_out_v;
  logic [23:0] m_p1_col, m_out_col;

  typedef struct {
    int kind;  // 0 data byte, 1 index write, 2 index+data same cycle
    int b;
  } host_op_t;
  host_op_t host_q[$];

  int pix_mode  = 0;   // 0 idle, 1 continuous, 2 random
  int pix_fixed = -1;
  int pix_span  = 256;
  int we_cnt    = 0;

  task automatic push(input int kind, input int b);
    host_op_t op;
    op.kind = kind;
    op.b    = b;
    host_q.push_back(op);
  endtask

  task automatic model_reset();
    m_idx = '0; m_r = '0; m_g = '0; m_pidx = '0; m_phase = 0; m_pv = 1'b0;
    m_pdata = '0; m_p1_v = 1'b0; m_out_v = 1'b0; m_p1_col = '0; m_out_col = '0;
  endtask

  task automatic cycle();
    logic       pv_in, iw, dw, rdy, cm;
    logic [7:0] px, hb;
    logic [23:0] col;
    @(negedge i_clk);
    check_val("pix_valid", 32'(o_pix_valid), 32'(m_out_v));
    check_val("color", 32'({o_b, o_g, o_r}), 32'(m_out_col));
    case (pix_mode)
      0:       pv_in = 1'b0;
      1:       pv_in = 1'b1;
      default: pv_in = 1'($urandom_range(0, 1));
    endcase
    px = (pix_fixed >= 0) ? 8'(pix_fixed) : 8'($urandom_range(0, pix_span - 1));
    iw = 1'b0; dw = 1'b0; hb = '0;
    if (host_q.size() != 0) begin
      iw = (host_q[0].kind != 0);
      dw = (host_q[0].kind != 1);
      hb = 8'(host_q[0].b);
    end
    i_pix_valid = pv_in; i_pix_index = px;
    i_host_idx_wr = iw; i_host_data_wr = dw; i_host_data = hb;
    #1;
    rdy = !(m_phase == 2 && m_pv);
    cm  = !pv_in && m_pv;
    check_val("host_ready", 32'(o_host_ready), 32'(rdy));
    check_val("ram_we", 32'(o_ram_we), 32'(cm));
    if (pv_in) check_val("ram_entry_pix", 32'(o_ram_entry), 32'(px));
    else if (m_pv) check_val("ram_entry_pend", 32'(o_ram_entry), 32'(m_pidx));
    if (cm) begin
      check_val("ram_data", 32'(o_ram_data), 32'(m_pdata));
      $display("commit entry=%02h data=%06h", m_pidx, m_pdata);
    end
    if (o_ram_we) we_cnt++;
    if ((iw || dw) && (iw || rdy)) void'(host_q.pop_front());

    // Palette semantics at transaction level.
    col = (FWD && m_pv && m_pidx == px) ? m_pdata : exp_mem[px];
    if (m_p1_v) m_out_col = m_p1_col;
    m_out_v = m_p1_v;
    m_p1_v  = pv_in;
    if (pv_in) m_p1_col = col;
    if (cm) begin
      exp_mem[m_pidx] = m_pdata;
      m_pv = 1'b0;
    end
    if (iw) begin
      m_idx = hb; m_phase = 0; m_r = '0; m_g = '0;
    end else if (dw && rdy) begin
      if (m_phase == 0) begin
        m_r = hb; m_phase = 1;
      end else if (m_phase == 1) begin
        m_g = hb; m_phase = 2;
      end else begin
        m_pv = 1'b1; m_pidx = m_idx; m_pdata = {hb, m_g, m_r};
        m_idx = m_idx + 8'd1; m_phase = 0;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic drain();
    int k = 0;
    while (host_q.size() != 0 && k < 3000) begin
      cycle();
      k++;
    end
    check_val("host_drain", 32'(host_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    i_pix_valid = 1'b0; i_host_idx_wr = 1'b0; i_host_data_wr = 1'b0; i_host_data = '0;
    host_q.delete();
    model_reset();
    #1;
    check_val("rst_ready", 32'(o_host_ready), 32'd1);
    check_val("rst_pix_valid", 32'(o_pix_valid), 32'd0);
    check_val("rst_color", 32'({o_b, o_g, o_r}), 32'd0);
    check_val("rst_ram_we", 32'(o_ram_we), 32'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    int we0;
    int r;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    ram_load = 1'b0;
    do_reset();
    run(3);

    // Single triple, no pixel traffic, then read it back.
    push(1, 8'h10); push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    drain(); run(3);
    check_val("ram_0x10", 32'(ram[8'h10]), 32'h0033_2211);
    pix_mode = 1; pix_fixed = 8'h10; run(1);
    pix_mode = 0; run(3);

    // Index wrap.
    push(1, 8'hFF);
    push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
    push(0, 8'h04); push(0, 8'h05); push(0, 8'h06);
    drain(); run(3);
    check_val("ram_0xff", 32'(ram[8'hFF]), 32'h0003_0201);
    check_val("ram_0x00", 32'(ram[8'h00]), 32'h0006_0504);

    // Starvation under continuous lookups of the pending index.
    we0 = we_cnt;
    pix_mode = 1; pix_fixed = 8'h40;
    push(1, 8'h40);
    push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
    push(0, 8'hB1); push(0, 8'hB2); push(0, 8'hB3);
    run(20);
    check_val("we_during_traffic", 32'(we_cnt - we0), 32'd0);
    check_val("b_byte_blocked", 32'(host_q.size()), 32'd1);
    pix_mode = 0; pix_fixed = -1;
    run(8);
    check_val("ram_0x40", 32'(ram[8'h40]), 32'h00A3_A2A1);
    check_val("ram_0x41", 32'(ram[8'h41]), 32'h00B3_B2B1);
    pix_mode = 1; pix_fixed = 8'h40; run(1);
    pix_mode = 0; pix_fixed = -1; run(3);

    // Index+data collision, then reset after the G byte.
    we0 = we_cnt;
    push(1, 8'h20); push(0, 8'h55); push(0, 8'h66);
    push(2, 8'h30); push(0, 8'h01); push(0, 8'h02);
    drain(); run(2);
    do_reset();
    run(3);
    check_val("no_write_after_reset", 32'(we_cnt - we0), 32'd0);
    push(0, 8'h07); push(0, 8'h08); push(0, 8'h09);
    drain(); run(3);
    check_val("ram_0x00_post_reset", 32'(ram[8'h00]), 32'h0009_0807);

    // Random mixed traffic confined to a small index window to provoke hits.
    pix_mode = 2; pix_fixed = -1; pix_span = 16;
    for (int i = 0; i < 240; i++) begin
      r = $urandom_range(0, 99);
      if (r < 85)      push(0, $urandom_range(0, 255));
      else if (r < 95) push(1, $urandom_range(0, 15));
      else             push(2, $urandom_range(0, 15));
    end
    drain();
    pix_mode = 0; pix_span = 256;
    run(4);
    for (int i = 0; i < 16; i++) begin
      pix_mode = 1; pix_fixed = i; run(1);
    end
    pix_mode = 0; pix_fixed = -1;
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
